// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_ctrl_pkg;

    localparam int SAC_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sac_state_e;

endpackage

// File: rtl/serial_adder_ctrl_fa_bit.sv
// One-bit full-adder cell; the serial controller feeds it one bit pair per clock.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: LSB-first through one fa_bit cell with a carry FF.
// sum/cout update only on the final-bit edge, so partial results are never visible.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = SAC_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    sac_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, s_sh_q, s_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_q, c_d, cout_q, cout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fa_s, fa_co;
    logic             accept, last_bit;

    fa_bit u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (c_q),
        .s    (fa_s),
        .cout (fa_co)
    );

    // Starts are honoured in IDLE and on the DONE cycle, never mid-operation.
    assign accept   = start && (state_q != SHIFT);
    assign last_bit = (state_q == SHIFT) && (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = accept ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_sh_d = a_sh_q;
        b_sh_d = b_sh_q;
        s_sh_d = s_sh_q;
        c_d    = c_q;
        cnt_d  = cnt_q;
        sum_d  = sum_q;
        cout_d = cout_q;
        if (accept) begin
            a_sh_d = a;
            b_sh_d = b;
            c_d    = cin;
            cnt_d  = '0;
        end else if (state_q == SHIFT) begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            s_sh_d = {fa_s, s_sh_q[WIDTH-1:1]};
            c_d    = fa_co;
            cnt_d  = cnt_q + CNT_W'(1);
            if (last_bit) begin
                sum_d  = {fa_s, s_sh_q[WIDTH-1:1]};
                cout_d = fa_co;
            end
        end
    end

    always_comb begin
        busy = (state_q == SHIFT);
        done = (state_q == DONE);
        sum  = sum_q;
        cout = cout_q;
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and randomized checks of serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;

    logic       clk, rst, start, cin;
    logic [7:0] a, b;
    logic       busy, done, cout;
    logic [7:0] sum;
    int         checks, errors;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one start and wait (bounded) for done; leaves time at the done cycle.
    task automatic run_add(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                           output int lat, output int nbusy,
                           output logic [7:0] s, output logic co);
        a = ia; b = ib; cin = ic; start = 1'b1;
        tick();
        start = 1'b0;
        lat = -1;
        nbusy = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            if (busy) nbusy++;
            tick();
        end
        s = sum;
        co = cout;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        tick(); tick();
        checks++;
        if ({busy, done, cout, sum} !== 11'b0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b cout=%b sum=%h, expected all zero", busy, done, cout, sum);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int lat, nb; logic [7:0] s; logic co;
        run_add(8'h5A, 8'h3C, 1'b0, lat, nb, s, co);
        checks++;
        if (lat !== 8) begin errors++; $display("FAIL basic_latency: got %0d expected 8", lat); end
        checks++;
        if (nb !== 8) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 8", nb); end
        checks++;
        if ({co, s} !== 9'h096) begin errors++; $display("FAIL basic_sum: got %b/%h expected 0/96", co, s); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_on_done: got %b expected 0", busy); end
        tick();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b expected 0", done); end
    endtask

    task automatic test_carry();
        int lat, nb; logic [7:0] s; logic co;
        run_add(8'hFF, 8'h01, 1'b0, lat, nb, s, co);
        checks++;
        if ({co, s} !== 9'h100) begin errors++; $display("FAIL carry_ff_01: got %b/%h expected 1/00", co, s); end
        tick();
        run_add(8'hFF, 8'hFF, 1'b1, lat, nb, s, co);
        checks++;
        if ({co, s} !== 9'h1FF) begin errors++; $display("FAIL carry_ff_ff_1: got %b/%h expected 1/ff", co, s); end
        tick();
    endtask

    task automatic test_ignore_start();
        int ndone, first; logic [7:0] s; logic co;
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0; first = -1; s = '0; co = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (k == 3) begin start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1; end
            if (k == 4) start = 1'b0;
            if (done) begin
                ndone++;
                if (first < 0) begin first = k; s = sum; co = cout; end
            end
            tick();
        end
        checks++;
        if (ndone !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", ndone); end
        checks++;
        if (first !== 8) begin errors++; $display("FAIL ignore_latency: got %0d expected 8", first); end
        checks++;
        if ({co, s} !== 9'h046) begin errors++; $display("FAIL ignore_sum: got %b/%h expected 0/46", co, s); end
        checks++;
        if ({cout, sum} !== 9'h046) begin errors++; $display("FAIL ignore_sum_held: got %b/%h expected 0/46", cout, sum); end
    endtask

    task automatic test_reset_mid();
        int lat, nb, ndone; logic [7:0] s; logic co;
        run_add(8'hFF, 8'h01, 1'b0, lat, nb, s, co);
        tick();
        a = 8'h77; b = 8'h11; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy, done, cout, sum} !== 11'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs: busy=%b done=%b cout=%b sum=%h expected all zero", busy, done, cout, sum);
        end
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            if (done || busy) ndone++;
            tick();
        end
        checks++;
        if (ndone !== 0) begin errors++; $display("FAIL reset_mid_no_done: activity cycles %0d expected 0", ndone); end
        run_add(8'h01, 8'h01, 1'b0, lat, nb, s, co);
        checks++;
        if (lat !== 8 || {co, s} !== 9'h002) begin
            errors++;
            $display("FAIL reset_mid_followup: lat=%0d sum=%b/%h expected 8 0/02", lat, co, s);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat, nb; logic [7:0] s; logic co;
        run_add(8'h0F, 8'h01, 1'b0, lat, nb, s, co);
        checks++;
        if ({co, s} !== 9'h010) begin errors++; $display("FAIL b2b_first: got %b/%h expected 0/10", co, s); end
        run_add(8'h80, 8'h80, 1'b0, lat, nb, s, co);
        checks++;
        if (lat !== 8) begin errors++; $display("FAIL b2b_latency: got %0d expected 8", lat); end
        checks++;
        if ({co, s} !== 9'h100) begin errors++; $display("FAIL b2b_sum: got %b/%h expected 1/00", co, s); end
        tick();
    endtask

    task automatic test_random();
        int lat, nb; logic [7:0] s, ra, rb; logic co, rc; logic [8:0] expv;
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            expv = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
            run_add(ra, rb, rc, lat, nb, s, co);
            checks++;
            if (lat !== 8 || {co, s} !== expv) begin
                errors++;
                $display("FAIL random_op %0d: %h+%h+%b lat=%0d got %b/%h expected 8 %b/%h",
                         n, ra, rb, rc, lat, co, s, expv[8], expv[7:0]);
            end
            tick();
            checks++;
            if (done !== 1'b0) begin errors++; $display("FAIL random_done_width %0d: got %b expected 0", n, done); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_carry();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
